// File: rtl/angle_gen_mc_if.sv
// angle_gen_mc_if: valid/ready configuration channel for angle_gen_mc.
interface angle_gen_mc_if #(
    parameter int WIDTH      = 12,
    parameter int FREQ_WIDTH = 16
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [FREQ_WIDTH-1:0] cfg_freq;
    logic [WIDTH-1:0]      cfg_step;
    logic [WIDTH-1:0]      cfg_offset;
    logic                  cfg_dir;
    logic [WIDTH-1:0]      cfg_amp;
    modport master (output cfg_valid, cfg_freq, cfg_step, cfg_offset, cfg_dir, cfg_amp, input cfg_ready);
    modport slave (input cfg_valid, cfg_freq, cfg_step, cfg_offset, cfg_dir, cfg_amp, output cfg_ready);
endinterface

// File: rtl/angle_gen_mc.sv
// angle_gen_mc: multi-channel phase generator feeding the CORDIC rotator.
// A shared period counter steps a master phase; config changes land on a period boundary.
module angle_gen_mc #(
    parameter int WIDTH      = 12,
    parameter int FREQ_WIDTH = 16,
    parameter int CNT        = 65536,
    parameter int NCH        = 4,
    parameter int STEP_RST   = 127,
    parameter int AMP_RST    = 1214
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 enable,
    angle_gen_mc_if.slave        cfg,
    output logic [NCH*WIDTH-1:0] angle,
    output logic                 angle_valid,
    output logic                 wrap,
    output logic [WIDTH-1:0]     x_start,
    output logic [WIDTH-1:0]     y_start
);
    localparam int CW = FREQ_WIDTH + 1;
    typedef struct packed {
        logic [FREQ_WIDTH-1:0] freq;
        logic [WIDTH-1:0]      step;
        logic [WIDTH-1:0]      offset;
        logic                  dir;
        logic [WIDTH-1:0]      amp;
    } cfg_t;
    localparam cfg_t CFG_RST = '{freq: '0, step: WIDTH'(STEP_RST), offset: '0, dir: 1'b0, amp: WIDTH'(AMP_RST)};
    cfg_t                 act;
    cfg_t                 shd;
    logic                 pending;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        term;
    logic [WIDTH-1:0]     phase;
    logic [WIDTH:0]       sum;
    logic [NCH*WIDTH-1:0] angle_nx;
    logic                 tick;
    assign cfg.cfg_ready = !pending;
    assign term = CW'(CNT) - CW'(act.freq);
    assign tick = enable && cnt == term;
    // Top bit of the widened add/subtract is the carry or borrow that marks a wrap.
    assign sum = act.dir ? {1'b0, phase} - {1'b0, act.step} : {1'b0, phase} + {1'b0, act.step};
    always_comb begin
        angle_nx = '0;
        for (int k = 0; k < NCH; k++) angle_nx[k*WIDTH +: WIDTH] = sum[WIDTH-1:0] + WIDTH'(k) * act.offset;
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            act         <= CFG_RST;
            shd         <= '0;
            pending     <= 1'b0;
            cnt         <= '0;
            phase       <= '0;
            angle       <= '0;
            angle_valid <= 1'b0;
            wrap        <= 1'b0;
            x_start     <= '0;
            y_start     <= '0;
        end else begin
            cnt         <= (tick || !enable) ? '0 : cnt + 1'b1;
            angle_valid <= tick;
            wrap        <= tick && sum[WIDTH];
            x_start     <= act.amp;
            y_start     <= '0;
            if (tick) begin
                phase <= sum[WIDTH-1:0];
                angle <= angle_nx;
            end
            // Apply uses the pre-tick config for this update; the new one governs the next period.
            if (pending && (tick || !enable)) begin
                act     <= shd;
                pending <= 1'b0;
            end else if (cfg.cfg_valid && !pending) begin
                shd     <= cfg_t'({cfg.cfg_freq, cfg.cfg_step, cfg.cfg_offset, cfg.cfg_dir, cfg.cfg_amp});
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_angle_gen_mc.sv
// tb_angle_gen_mc: directed scenarios with a pulse scoreboard for angle_gen_mc.
`timescale 1ns/1ps
module tb_angle_gen_mc;
    localparam int W   = 12;
    localparam int FW  = 16;
    localparam int NCH = 4;
    typedef struct {
        logic [NCH*W-1:0] ang;
        logic             wr;
        int               gap;
    } exp_t;
    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic             enable = 1'b0;
    logic [NCH*W-1:0] angle;
    logic             angle_valid;
    logic             wrap;
    logic [W-1:0]     x_start;
    logic [W-1:0]     y_start;
    exp_t             q[$];
    exp_t             e;
    int               n_chk = 0;
    int               n_fail = 0;
    int               cyc = 0;
    int               last_cyc = 0;
    angle_gen_mc_if #(.WIDTH(W), .FREQ_WIDTH(FW)) cfg_bus ();
    angle_gen_mc dut (
        .clock(clock), .resetn(resetn), .enable(enable), .cfg(cfg_bus),
        .angle(angle), .angle_valid(angle_valid), .wrap(wrap),
        .x_start(x_start), .y_start(y_start)
    );
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask
    function automatic logic [NCH*W-1:0] chans(int a0, int off);
        logic [NCH*W-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*W +: W] = W'((a0 + k * off) % 4096);
        return r;
    endfunction
    task automatic push(logic [NCH*W-1:0] a, logic wr, int gap);
        q.push_back('{a, wr, gap});
    endtask
    // Scoreboard monitor: every angle_valid pulse must match the next queued expectation.
    always @(negedge clock) begin
        if (resetn && angle_valid) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: angle_valid=1 at cycle %0d, none expected", cyc);
            end else begin
                e = q.pop_front();
                chk("angle", angle, e.ang);
                chk("wrap", wrap, e.wr);
                chk("period", cyc - last_cyc, e.gap);
                chk("x_start", x_start, 1214);
                chk("y_start", y_start, 0);
            end
            last_cyc = cyc;
        end else if (resetn && wrap) begin
            n_chk++;
            n_fail++;
            $display("FAIL stray_wrap: wrap=1 without angle_valid at cycle %0d", cyc);
        end
    end
    task automatic step_clk(int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask
    task automatic go();
        enable = 1'b1;
        last_cyc = cyc;
    endtask
    task automatic do_reset();
        resetn = 1'b0;
        step_clk(2);
        resetn = 1'b1;
    endtask
    task automatic send_cfg(int freq, int stp, int off, bit dir, int amp);
        cfg_bus.cfg_freq   = FW'(freq);
        cfg_bus.cfg_step   = W'(stp);
        cfg_bus.cfg_offset = W'(off);
        cfg_bus.cfg_dir    = dir;
        cfg_bus.cfg_amp    = W'(amp);
        cfg_bus.cfg_valid  = 1'b1;
        for (int i = 0; i < 200 && !cfg_bus.cfg_ready; i++) step_clk();
        if (!cfg_bus.cfg_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL cfg_accept: cfg_ready=0 after 200 cycles, expected 1");
        end
        step_clk();
        cfg_bus.cfg_valid = 1'b0;
    endtask
    task automatic wait_drain(int budget);
        int i = 0;
        while (q.size() != 0 && i < budget) begin
            step_clk();
            i++;
        end
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d pulses outstanding after %0d cycles, expected 0", q.size(), budget);
            q.delete();
        end
    endtask
    initial begin
        int ph;
        int nx;
        cfg_bus.cfg_valid  = 1'b0;
        cfg_bus.cfg_freq   = '0;
        cfg_bus.cfg_step   = '0;
        cfg_bus.cfg_offset = '0;
        cfg_bus.cfg_dir    = 1'b0;
        cfg_bus.cfg_amp    = '0;
        step_clk(2);
        chk("rst_angle", angle, 0);
        chk("rst_valid", angle_valid, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_x_start", x_start, 0);
        chk("rst_y_start", y_start, 0);
        chk("rst_ready", cfg_bus.cfg_ready, 1);
        resetn = 1'b1;
        step_clk();
        chk("x_start_after_rst", x_start, 1214);
        // Basic run: term=2, period 3, offset 0.
        send_cfg(65534, 127, 0, 0, 1214);
        chk("ready_pending", cfg_bus.cfg_ready, 0);
        step_clk();
        chk("ready_after_apply", cfg_bus.cfg_ready, 1);
        go();
        push(chans(127, 0), 0, 3);
        push(chans(254, 0), 0, 3);
        push(chans(381, 0), 0, 3);
        push(chans(508, 0), 0, 3);
        wait_drain(50);
        // Quadrature offsets and the wrap on the 33rd update.
        enable = 1'b0;
        do_reset();
        send_cfg(65534, 127, 1024, 0, 1214);
        step_clk();
        go();
        push({12'd3199, 12'd2175, 12'd1151, 12'd127}, 0, 3);
        ph = 127;
        for (int i = 2; i <= 33; i++) begin
            nx = ph + 127;
            push(chans(nx % 4096, 1024), nx >= 4096, 3);
            ph = nx % 4096;
        end
        wait_drain(200);
        chk("ch0_after_33", angle[W-1:0], 95);
        // Decrementing phase borrows on the first update.
        enable = 1'b0;
        do_reset();
        send_cfg(65534, 127, 0, 1, 1214);
        step_clk();
        go();
        push(chans(3969, 0), 1, 3);
        push(chans(3842, 0), 0, 3);
        wait_drain(50);
        // Mid-period config: old step/term for this tick, new ones after; held valid accepted once.
        push(chans(3715, 0), 0, 3);
        push(chans(3725, 0), 0, 5);
        push(chans(3745, 0), 0, 4);
        push(chans(3765, 0), 0, 4);
        send_cfg(65532, 10, 0, 0, 1214);
        chk("ready_low_midperiod", cfg_bus.cfg_ready, 0);
        send_cfg(65533, 20, 0, 0, 1214);
        chk("ready_after_second", cfg_bus.cfg_ready, 0);
        wait_drain(100);
        chk("ready_idle", cfg_bus.cfg_ready, 1);
        // Disable at cnt=1 for 10 cycles; re-enable restarts a full period.
        enable = 1'b0;
        step_clk(10);
        chk("angle_held", angle[W-1:0], 3765);
        go();
        push(chans(3785, 0), 0, 4);
        wait_drain(50);
        // Async reset with a config pending: everything clears and the pending word is lost.
        send_cfg(65535, 500, 7, 1, 999);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_angle", angle, 0);
        chk("async_valid", angle_valid, 0);
        chk("async_wrap", wrap, 0);
        chk("async_x_start", x_start, 0);
        chk("async_y_start", y_start, 0);
        chk("async_ready", cfg_bus.cfg_ready, 1);
        enable = 1'b0;
        step_clk(2);
        resetn = 1'b1;
        step_clk(3);
        chk("post_rst_x_start", x_start, 1214);
        chk("post_rst_angle", angle, 0);
        chk("post_rst_ready", cfg_bus.cfg_ready, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
